// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment display path (encoder and scan decoder).
//   SEG_0..SEG_9, SEG_OFF : common-cathode segment patterns, bit 6..0 = a..g
//   BCD_BLANK             : nibble used for a dark digit
//   scan_state_e          : scan decoder FSM states
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SETTLE = 2'd1,
        CAPTD  = 2'd2
    } scan_state_e;

    // Exactly one digit enable active; 00 is idle and 11 is ghosting.
    function automatic logic isOneHot2(input logic [1:0] dig);
        return dig[1] ^ dig[0];
    endfunction

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// seg7_pattern_to_bcd
// Combinational inverse of the BCD->7-segment encoder.
//   i_seg   in  7  segment pattern, bit 6..0 = a..g
//   o_legal out 1  pattern is a digit 0..9 or fully blank
//   o_bcd   out 4  decoded digit, BCD_BLANK for blank or illegal patterns
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic [3:0] o_bcd
);

    always_comb begin
        o_legal = 1'b1;
        o_bcd   = BCD_BLANK;
        case (i_seg)
            SEG_0:   o_bcd = 4'd0;
            SEG_1:   o_bcd = 4'd1;
            SEG_2:   o_bcd = 4'd2;
            SEG_3:   o_bcd = 4'd3;
            SEG_4:   o_bcd = 4'd4;
            SEG_5:   o_bcd = 4'd5;
            SEG_6:   o_bcd = 4'd6;
            SEG_7:   o_bcd = 4'd7;
            SEG_8:   o_bcd = 4'd8;
            SEG_9:   o_bcd = 4'd9;
            SEG_OFF: o_bcd = BCD_BLANK;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Monitors a 2-digit multiplexed segment bus, accepts each digit only after it has
// been stable for STABLE_CYC samples, decodes it and commits a tens/units pair once
// both digits have been captured.
//   i_clk   in  1  clock, rising edge
//   i_rst   in  1  asynchronous active-high reset
//   i_seg   in  7  segment bus a..g, active high
//   i_dig   in  2  digit enables, [1]=tens, [0]=units
//   o_tens  out 4  last committed tens digit (BCD_BLANK = blank)
//   o_units out 4  last committed units digit (BCD_BLANK = blank)
//   o_valid out 1  a commit happened within the last TIMEOUT_CYC cycles
//   o_upd   out 1  one-cycle pulse per commit
//   o_err   out 1  one-cycle pulse when a stable illegal pattern is captured
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seg,
    input  logic [1:0] i_dig,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_valid,
    output logic       o_upd,
    output logic       o_err
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYC);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC);

    scan_state_e      r_state;
    scan_state_e      w_nextState;
    logic [8:0]       r_ref;
    logic [CNT_W-1:0] r_cnt;
    logic [WD_W-1:0]  r_wd;
    logic [3:0]       r_slotTens;
    logic [3:0]       r_slotUnits;
    logic             r_flagTens;
    logic             r_flagUnits;
    logic [3:0]       r_tens;
    logic [3:0]       r_units;
    logic             r_valid;
    logic             r_upd;
    logic             r_err;

    logic [8:0]       w_sample;
    logic             w_match;
    logic             w_oneHot;
    logic             w_loadRef;
    logic             w_cntInc;
    logic             w_capture;
    logic             w_commit;
    logic             w_legal;
    logic [3:0]       w_bcd;

    assign w_sample = {i_seg, i_dig};
    assign w_match  = (w_sample == r_ref);
    assign w_oneHot = isOneHot2(i_dig);
    assign w_commit = r_flagTens & r_flagUnits;

    // REF holds the sample being settled, so at capture time its segment field is
    // the pattern to decode and its digit field selects the slot.
    seg7_pattern_to_bcd u_decode (
        .i_seg   (r_ref[8:2]),
        .o_legal (w_legal),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= HUNT;
        else       r_state <= w_nextState;
    end

    // The HUNT sample counts as the first of the STABLE_CYC identical samples, so
    // capture fires on the edge where the counter would reach STABLE_CYC.
    always_comb begin
        w_nextState = r_state;
        w_loadRef   = 1'b0;
        w_cntInc    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_oneHot) begin
                    w_loadRef   = 1'b1;
                    w_nextState = SETTLE;
                end
            end
            SETTLE: begin
                if (w_match) begin
                    w_cntInc = 1'b1;
                    if (r_cnt >= CNT_LAST) begin
                        w_capture   = 1'b1;
                        w_nextState = CAPTD;
                    end
                end else if (w_oneHot) begin
                    w_loadRef = 1'b1;
                end else begin
                    w_nextState = HUNT;
                end
            end
            CAPTD: begin
                if (!w_match) w_nextState = HUNT;
            end
            default: w_nextState = HUNT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ref <= '0;
            r_cnt <= '0;
        end else if (w_loadRef) begin
            r_ref <= w_sample;
            r_cnt <= CNT_W'(1);
        end else if (w_cntInc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Capture and commit never coincide: capture only leaves SETTLE, and the commit
    // edge always follows the capture edge while the FSM is already in CAPTD.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slotTens  <= BCD_BLANK;
            r_slotUnits <= BCD_BLANK;
            r_flagTens  <= 1'b0;
            r_flagUnits <= 1'b0;
            r_tens      <= BCD_BLANK;
            r_units     <= BCD_BLANK;
            r_upd       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            r_err <= 1'b0;
            if (w_commit) begin
                r_tens      <= r_slotTens;
                r_units     <= r_slotUnits;
                r_flagTens  <= 1'b0;
                r_flagUnits <= 1'b0;
                r_upd       <= 1'b1;
            end
            if (w_capture) begin
                if (!w_legal) begin
                    r_err <= 1'b1;
                end else if (r_ref[1]) begin
                    r_slotTens <= w_bcd;
                    r_flagTens <= 1'b1;
                end else begin
                    r_slotUnits <= w_bcd;
                    r_flagUnits <= 1'b1;
                end
            end
        end
    end

    // Watchdog saturates at TIMEOUT_CYC; a commit on the expiry edge takes priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd    <= '0;
            r_valid <= 1'b0;
        end else if (w_commit) begin
            r_wd    <= '0;
            r_valid <= 1'b1;
        end else if (r_wd != WD_MAX) begin
            r_wd <= r_wd + WD_W'(1);
            if (r_wd == WD_LAST) r_valid <= 1'b0;
        end
    end

    assign o_tens  = r_tens;
    assign o_units = r_units;
    assign o_valid = r_valid;
    assign o_upd   = r_upd;
    assign o_err   = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Directed bench for seg7_scan_decoder with STABLE_CYC=4, TIMEOUT_CYC=20.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_seg7_scan_decoder;

    localparam logic [6:0] P0    = 7'b1111110;
    localparam logic [6:0] P1    = 7'b0110000;
    localparam logic [6:0] P2    = 7'b1101101;
    localparam logic [6:0] P3    = 7'b1111001;
    localparam logic [6:0] P4    = 7'b0110011;
    localparam logic [6:0] P5    = 7'b1011011;
    localparam logic [6:0] P7    = 7'b1110000;
    localparam logic [6:0] P8    = 7'b1111111;
    localparam logic [6:0] PBAD  = 7'b1000001;
    localparam logic [6:0] POFF  = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [1:0] dig;
    logic [3:0] tens;
    logic [3:0] units;
    logic       valid;
    logic       upd;
    logic       err;

    int nCompared   = 0;
    int nMismatched = 0;

    seg7_scan_decoder #(
        .STABLE_CYC  (4),
        .TIMEOUT_CYC (20)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_seg   (seg),
        .i_dig   (dig),
        .o_tens  (tens),
        .o_units (units),
        .o_valid (valid),
        .o_upd   (upd),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    // Present one bus sample for exactly one rising edge, return just after it.
    task automatic drive(input logic [6:0] s, input logic [1:0] d);
        @(negedge clk);
        seg = s;
        dig = d;
        @(posedge clk);
        #1;
    endtask

    // Reset values are visible before the first clock edge.
    task automatic test_reset;
        rst = 1'b1;
        seg = POFF;
        dig = 2'b00;
        #2;
        nCompared++;
        if (tens !== 4'hF) begin nMismatched++; $display("[TB] FAIL reset_tens: got %h want F", tens); end
        nCompared++;
        if (units !== 4'hF) begin nMismatched++; $display("[TB] FAIL reset_units: got %h want F", units); end
        nCompared++;
        if ({valid, upd, err} !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_flags: got %b want 000", {valid, upd, err}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Tens 3 then units 1. The first units sample hits CAPTD and only returns to
    // HUNT, so units capture is 4 edges later and the commit one edge after that.
    task automatic test_normal_frame;
        for (int i = 1; i <= 4; i++) begin
            drive(P3, 2'b10);
            nCompared++;
            if (upd !== 1'b0) begin nMismatched++; $display("[TB] FAIL frame_tens_upd%0d: got %b want 0", i, upd); end
        end
        for (int i = 1; i <= 6; i++) begin
            drive(P1, 2'b01);
            nCompared++;
            if (upd !== (i == 6)) begin nMismatched++; $display("[TB] FAIL frame_units_upd%0d: got %b want %b", i, upd, (i == 6)); end
        end
        nCompared++;
        if ({tens, units} !== 8'h31) begin nMismatched++; $display("[TB] FAIL frame_value: got %h want 31", {tens, units}); end
        nCompared++;
        if (valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL frame_valid: got %b want 1", valid); end
        drive(P1, 2'b01);
        nCompared++;
        if (upd !== 1'b0) begin nMismatched++; $display("[TB] FAIL frame_upd_single: got %b want 0", upd); end
    endtask

    // Reset asserted between clock edges while settling a tens digit.
    task automatic test_reset_mid_settle;
        drive(POFF, 2'b00);
        drive(P7, 2'b10);
        drive(P7, 2'b10);
        #2;
        rst = 1'b1;
        seg = POFF;
        dig = 2'b00;
        #1;
        nCompared++;
        if ({tens, units} !== 8'hFF) begin nMismatched++; $display("[TB] FAIL midrst_value: got %h want FF", {tens, units}); end
        nCompared++;
        if ({valid, upd, err} !== 3'b000) begin nMismatched++; $display("[TB] FAIL midrst_flags: got %b want 000", {valid, upd, err}); end
        @(negedge clk);
        rst = 1'b0;
        // Only a units digit now; no commit may happen without a fresh tens capture.
        for (int i = 1; i <= 6; i++) begin
            drive(P5, 2'b01);
            nCompared++;
            if (upd !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_no_commit%0d: got %b want 0", i, upd); end
        end
        nCompared++;
        if (tens !== 4'hF) begin nMismatched++; $display("[TB] FAIL midrst_tens_held: got %h want F", tens); end
    endtask

    // A one-sample glitch restarts the count; units 5 is still pending from before.
    task automatic test_glitch;
        drive(POFF, 2'b00);
        drive(P3, 2'b10);
        drive(P3, 2'b10);
        drive(P8, 2'b10);
        for (int i = 1; i <= 4; i++) begin
            drive(P3, 2'b10);
            nCompared++;
            if (upd !== 1'b0) begin nMismatched++; $display("[TB] FAIL glitch_no_upd%0d: got %b want 0", i, upd); end
        end
        drive(P3, 2'b10);
        nCompared++;
        if (upd !== 1'b1) begin nMismatched++; $display("[TB] FAIL glitch_upd: got %b want 1", upd); end
        nCompared++;
        if ({tens, units} !== 8'h35) begin nMismatched++; $display("[TB] FAIL glitch_value: got %h want 35", {tens, units}); end
    endtask

    // Stable illegal pattern on units: ERR on the 4th sample, nothing committed.
    task automatic test_illegal;
        drive(POFF, 2'b00);
        for (int i = 1; i <= 5; i++) begin
            drive(PBAD, 2'b01);
            nCompared++;
            if (err !== (i == 4)) begin nMismatched++; $display("[TB] FAIL illegal_err%0d: got %b want %b", i, err, (i == 4)); end
            nCompared++;
            if (upd !== 1'b0) begin nMismatched++; $display("[TB] FAIL illegal_upd%0d: got %b want 0", i, upd); end
        end
        nCompared++;
        if (units !== 4'h5) begin nMismatched++; $display("[TB] FAIL illegal_units: got %h want 5", units); end
    endtask

    // Ghosting is ignored; a blank tens digit is legal. The units flag must still
    // be clear after the illegal capture, so no commit follows the tens capture.
    task automatic test_blank_ghost;
        for (int i = 1; i <= 10; i++) begin
            drive(P8, 2'b11);
            nCompared++;
            if ({upd, err} !== 2'b00) begin nMismatched++; $display("[TB] FAIL ghost%0d: got %b want 00", i, {upd, err}); end
        end
        for (int i = 1; i <= 4; i++) drive(POFF, 2'b10);
        for (int i = 1; i <= 6; i++) begin
            drive(P0, 2'b01);
            nCompared++;
            if (upd !== (i == 6)) begin nMismatched++; $display("[TB] FAIL blank_upd%0d: got %b want %b", i, upd, (i == 6)); end
        end
        nCompared++;
        if ({tens, units} !== 8'hF0) begin nMismatched++; $display("[TB] FAIL blank_value: got %h want F0", {tens, units}); end
    endtask

    // Commit happened on the last drive; VALID must fall on the 20th idle edge.
    task automatic test_timeout;
        for (int i = 1; i <= 20; i++) begin
            drive(POFF, 2'b00);
            nCompared++;
            if (valid !== (i < 20)) begin nMismatched++; $display("[TB] FAIL timeout_valid%0d: got %b want %b", i, valid, (i < 20)); end
        end
        nCompared++;
        if ({tens, units} !== 8'hF0) begin nMismatched++; $display("[TB] FAIL timeout_held: got %h want F0", {tens, units}); end
        for (int i = 1; i <= 4; i++) drive(P4, 2'b10);
        for (int i = 1; i <= 5; i++) drive(P2, 2'b01);
        nCompared++;
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL timeout_still_low: got %b want 0", valid); end
        drive(P2, 2'b01);
        nCompared++;
        if ({upd, valid} !== 2'b11) begin nMismatched++; $display("[TB] FAIL timeout_recover: got %b want 11", {upd, valid}); end
        nCompared++;
        if ({tens, units} !== 8'h42) begin nMismatched++; $display("[TB] FAIL timeout_value: got %h want 42", {tens, units}); end
    endtask

    initial begin
        $display("[TB] seg7_scan_decoder directed tests");
        test_reset();
        test_normal_frame();
        test_reset_mid_settle();
        test_glitch();
        test_illegal();
        test_blank_ghost();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
